pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of PC and all address ports.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter IALIGN, default 4, legal instruction alignment in bytes (2 or 4).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 if_ready  in  1  fetch accepts current pc this cycle.
REQ-008 stall  in  1  freeze PC (pipeline hazard).
REQ-009 trap_req  in  1  redirect to trap_vector.
REQ-010 trap_vector  in  XLEN  trap handler address.
REQ-011 jalr_req  in  1  redirect to jalr_target.
REQ-012 jalr_target  in  XLEN  rs1+imm, unmasked.
REQ-013 br_req  in  1  taken branch or JAL.
REQ-014 br_base  in  XLEN  PC of the branch/JAL instruction.
REQ-015 br_offset  in  XLEN  sign-extended byte offset (bit 0 always 0).
REQ-016 pc  out  XLEN  current fetch address.
REQ-017 pc_valid  out  1  pc is a legal fetch address.
REQ-018 flush  out  1  one-cycle pulse, younger fetches are invalid.
REQ-019 misaligned  out  1  misaligned redirect target detected.
REQ-020 bad_addr  out  XLEN  offending target address.

Function
REQ-021 FSM states: BOOT, RUN, HALT.
REQ-022 BOOT: pc_valid=0, pc=RESET_VECTOR; next cycle -> RUN unconditionally (one bubble after reset release).
REQ-023 RUN: pc_valid=1.
REQ-024 Redirect priority: trap_req > jalr_req > br_req; lower-priority requests ignored same cycle.
REQ-025 jalr target = jalr_target with bit 0 cleared.
REQ-026 br target = br_base + br_offset, modulo 2^XLEN (wrap, no carry-out).
REQ-027 Redirect (any req, RUN) overrides stall and if_ready; pc <= target next cycle; flush=1 in the cycle the redirect is accepted.
REQ-028 No redirect, stall=0, if_ready=1: pc <= pc + 4, modulo 2^XLEN.
REQ-029 No redirect and (stall=1 or if_ready=0): pc holds.
REQ-030 Misalignment: jalr/br target with (target mod IALIGN) != 0 -> pc unchanged, misaligned<=1, bad_addr<=target, flush=1, state -> HALT.
REQ-031 Trap targets never checked for alignment.
REQ-032 HALT: pc_valid=0, pc holds, jalr_req/br_req ignored; only trap_req exits.
REQ-033 trap_req in HALT: pc <= trap_vector, misaligned<=0, flush=1, state -> RUN.
REQ-034 trap_req in RUN also clears misaligned (already 0) and is never blocked.
REQ-035 Requests in BOOT ignored; flush=0 in BOOT.
REQ-036 flush is combinational on accepted redirect/misalignment, registered pc; bad_addr holds until next misalignment.

Reset
REQ-037 rst=1 asynchronously: state=BOOT, pc=RESET_VECTOR, pc_valid=0, misaligned=0, bad_addr=0, flush=0.
REQ-038 rst asserted mid-HALT or mid-redirect discards all pending state; no request is remembered.

Verification
REQ-039 Reset release, if_ready=1, no reqs -> cycle0 pc_valid=0 pc=0; then pc 0,4,8,12 with pc_valid=1.
REQ-040 At pc=0x10: stall=1 for 3 cycles -> pc stays 0x10; br_req with stall=1, br_base=0x10, br_offset=0xFFFFFFF0 -> flush=1, next pc=0x0.
REQ-041 trap_req, jalr_req, br_req same cycle, trap_vector=0x100 -> next pc=0x100, flush=1.
REQ-042 jalr_target=0x203 -> next pc=0x202; IALIGN=4 -> misaligned=1, bad_addr=0x202, pc_valid=0, HALT; br_req ignored; trap_req to 0x80 -> pc=0x80, misaligned=0, RUN.
REQ-043 pc=0xFFFFFFFC, if_ready=1 -> next pc=0x0; br_base=0xFFFFFFF8, br_offset=0x10 -> pc=0x8.
REQ-044 rst pulsed while in HALT -> immediate pc=RESET_VECTOR, misaligned=0, BOOT then RUN.

Source files
------------

// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch, prioritized trap/jalr/branch redirects,
// and a halt state entered on a misaligned jalr/branch target that only a trap can leave.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_ready,
  input  logic            stall,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            jalr_req,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            br_req,
  input  logic [XLEN-1:0] br_base,
  input  logic [XLEN-1:0] br_offset,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] BIT0_CLR   = ~XLEN'(1);

  logic [1:0]      state, state_d;
  logic [XLEN-1:0] pc_d, bad_d;
  logic            mis_d;
  logic [XLEN-1:0] jalr_tgt, br_tgt, sel_tgt;

  assign jalr_tgt = jalr_target & BIT0_CLR;
  assign br_tgt   = br_base + br_offset;
  assign sel_tgt  = jalr_req ? jalr_tgt : br_tgt;

  // Next-state and redirect decode; flush is a same-cycle indication of an accepted redirect.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    mis_d   = misaligned;
    bad_d   = bad_addr;
    flush   = 1'b0;
    case (state)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_req) begin
          flush = 1'b1;
          pc_d  = trap_vector;
          mis_d = 1'b0;
        end else if (jalr_req || br_req) begin
          flush = 1'b1;
          if ((sel_tgt & ALIGN_MASK) != '0) begin
            mis_d   = 1'b1;
            bad_d   = sel_tgt;
            state_d = HALT;
          end else begin
            pc_d = sel_tgt;
          end
        end else if (!stall && if_ready) begin
          pc_d = pc + PC_STEP;
        end
      end
      HALT: begin
        if (trap_req) begin
          flush   = 1'b1;
          pc_d    = trap_vector;
          mis_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      pc_valid   <= 1'b0;
      misaligned <= 1'b0;
      bad_addr   <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      pc_valid   <= (state_d == RUN);
      misaligned <= mis_d;
      bad_addr   <= bad_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios followed by random traffic, checked against a
// cycle-level behavioural model of the fetch address rules.
module tb_pc_gen;

  localparam logic [31:0] RV     = 32'h0;
  localparam int unsigned IALIGN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready, stall, trap_req, jalr_req, br_req;
  logic [31:0] trap_vector, jalr_target, br_base, br_offset;
  logic [31:0] pc, bad_addr;
  logic        pc_valid, flush, misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = waiting one cycle after reset, 1 = fetching, 2 = halted on bad target.
  int          m_mode;
  logic [31:0] m_pc, m_bad;
  logic        m_mis;

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(IALIGN)) dut (
    .clk(clk), .rst(rst), .if_ready(if_ready), .stall(stall),
    .trap_req(trap_req), .trap_vector(trap_vector),
    .jalr_req(jalr_req), .jalr_target(jalr_target),
    .br_req(br_req), .br_base(br_base), .br_offset(br_offset),
    .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .misaligned(misaligned), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (trap_req) begin
        m_pc = trap_vector; m_mis = 1'b0;
      end else if (jalr_req || br_req) begin
        tgt = jalr_req ? {jalr_target[31:1], 1'b0} : br_base + br_offset;
        if (tgt % IALIGN != 0) begin
          m_mis = 1'b1; m_bad = tgt; m_mode = 2;
        end else begin
          m_pc = tgt;
        end
      end else if (!stall && if_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end else if (trap_req) begin
      m_pc = trap_vector; m_mis = 1'b0; m_mode = 1;
    end
  endtask

  task automatic clear_inputs();
    if_ready = 1'b0; stall = 1'b0; trap_req = 1'b0; jalr_req = 1'b0; br_req = 1'b0;
    trap_vector = '0; jalr_target = '0; br_base = '0; br_offset = '0;
  endtask

  // Asserts reset between edges and checks that outputs respond before any clock edge.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_pc", pc, RV);
    check("rst_valid", 32'(pc_valid), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_bad", bad_addr, 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    m_mode = 0; m_pc = RV; m_mis = 1'b0; m_bad = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cycle(input logic t, input logic [31:0] tv, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bb, input logic [31:0] bo,
                       input logic st, input logic rdy);
    logic exp_flush;
    trap_req = t; trap_vector = tv; jalr_req = j; jalr_target = jt;
    br_req = b; br_base = bb; br_offset = bo; stall = st; if_ready = rdy;
    @(negedge clk);
    exp_flush = (m_mode == 1 && (t || j || b)) || (m_mode == 2 && t);
    check("pc", pc, m_pc);
    check("pc_valid", 32'(pc_valid), 32'(m_mode == 1));
    check("flush", 32'(flush), 32'(exp_flush));
    check("misaligned", 32'(misaligned), 32'(m_mis));
    check("bad_addr", bad_addr, m_bad);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic        rt, rj, rb, rs, rr;
    logic [31:0] rtv, rjt, rbb, rbo;

    do_reset();
    // Boot bubble, then sequential fetch 0,4,8,12
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("boot_exit_pc", pc, 32'h0);
    check("boot_exit_valid", 32'(pc_valid), 32'd1);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("seq_pc10", pc, 32'h10);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("stall_hold", pc, 32'h10);
    cycle(0, 0, 0, 0, 1, 32'h10, 32'hFFFF_FFF0, 1, 1);
    check("br_over_stall", pc, 32'h0);
    cycle(1, 32'h100, 1, 32'h40, 1, 32'h0, 32'h20, 0, 1);
    check("trap_prio", pc, 32'h100);
    cycle(0, 0, 1, 32'h203, 0, 0, 0, 0, 1);
    check("jalr_mis_pc", pc, 32'h100);
    check("jalr_mis_flag", 32'(misaligned), 32'd1);
    check("jalr_mis_bad", bad_addr, 32'h202);
    check("halt_valid", 32'(pc_valid), 32'd0);
    cycle(0, 0, 0, 0, 1, 32'h0, 32'h40, 0, 1);
    check("halt_ignore_br", pc, 32'h100);
    cycle(1, 32'h80, 0, 0, 0, 0, 0, 0, 1);
    check("halt_trap_pc", pc, 32'h80);
    check("halt_trap_mis", 32'(misaligned), 32'd0);
    cycle(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("pc_wrap", pc, 32'h0);
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'h10, 0, 0);
    check("br_wrap", pc, 32'h8);
    cycle(0, 0, 1, 32'h206, 0, 0, 0, 0, 1);
    check("halt_again", 32'(misaligned), 32'd1);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("post_rst_valid", 32'(pc_valid), 32'd1);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 300 == 0) do_reset();
      rt  = ($urandom % 16 == 0);
      rj  = ($urandom % 8 == 0);
      rb  = ($urandom % 4 == 0);
      rs  = ($urandom % 4 == 0);
      rr  = ($urandom % 5 != 0);
      rtv = $urandom & 32'hFFFF_FFFC;
      rjt = $urandom;
      if ($urandom % 8 != 0) rjt[1] = 1'b0;
      rbb = $urandom & 32'hFFFF_FFFC;
      rbo = $urandom & 32'hFFFF_FFFE;
      if ($urandom % 4 != 0) rbo[1] = 1'b0;
      cycle(rt, rtv, rj, rjt, rb, rbb, rbo, rs, rr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
